jtag_selftest_seq: RTL

JTAG_SELFTEST_SEQ -- requirements
Module: jtag_selftest_seq

---
 rtl/jtag_selftest_seq.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/jtag_selftest_seq.sv
`timescale 1ns/1ps
// Purpose: loopback self-test sequencer; walks 8 patterns onto DRV and compares against synchronized SNS.
// Latency: one run = (SETTLE_CYCLES+1) enter + 8*(SETTLE_CYCLES+1) patterns + 1 exit cycles, then a 1-cycle DONE.
// Backpressure: none; START is ignored while BUSY, ABORT cuts a run short through EXIT.
//
// Ports:
//   CLK, nRST            clock, async active-low reset
//   START, ABORT         level controls (START honoured in IDLE/DONE_ST, ABORT in ENTER..SAMPLE)
//   TEST_MODE            0 while the buffer is in loopback test, 1 for normal operation
//   DRV / SNS            driven pattern and its asynchronous loopback return, bit-aligned
//   BUSY, DONE, PASS, ABORTED, ERR_MASK, FAIL_IDX   registered status/results
module jtag_selftest_seq #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       START,
    input  logic       ABORT,
    output logic       TEST_MODE,
    output logic [3:0] DRV,
    input  logic [3:0] SNS,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic       ABORTED,
    output logic [3:0] ERR_MASK,
    output logic [2:0] FAIL_IDX
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        DRIVE   = 3'd2,
        SETTLE  = 3'd3,
        SAMPLE  = 3'd4,
        EXIT    = 3'd5,
        DONE_ST = 3'd6
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic [3:0] sns_meta;
    logic [3:0] sns_sync;

    logic [2:0] idx_nxt;
    logic [7:0] cnt_nxt;
    logic [3:0] err_nxt;
    logic [2:0] fidx_nxt;
    logic       pass_nxt;
    logic       aborted_nxt;
    logic       test_mode_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic [3:0] drv_nxt;
    logic [3:0] mism;
    logic       in_run_nxt;

    // Walking one, then walking zero.
    function automatic logic [3:0] pattern_at(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0010;
            3'd2:    p = 4'b0100;
            3'd3:    p = 4'b1000;
            3'd4:    p = 4'b1110;
            3'd5:    p = 4'b1101;
            3'd6:    p = 4'b1011;
            default: p = 4'b0111;
        endcase
        return p;
    endfunction

    // SNS comes back through external pads with no timing relationship to CLK.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sns_meta <= 4'b0000;
            sns_sync <= 4'b0000;
        end else begin
            sns_meta <= SNS;
            sns_sync <= sns_meta;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = ENTER;
            // ENTER runs the counter from SETTLE_CYCLES down to 0: one cycle to
            // flip TEST_MODE plus SETTLE_CYCLES cycles of hold.
            ENTER:   if (ABORT) state_nxt = EXIT;
                     else if (cnt == 8'd0) state_nxt = DRIVE;
            DRIVE:   state_nxt = ABORT ? EXIT : SETTLE;
            // Leave when the decrement lands on zero so DRIVE+SETTLE+SAMPLE
            // spans exactly SETTLE_CYCLES+1 cycles.
            SETTLE:  if (ABORT) state_nxt = EXIT;
                     else if (cnt <= 8'd1) state_nxt = SAMPLE;
            SAMPLE:  if (ABORT || idx == 3'd7) state_nxt = EXIT;
                     else state_nxt = DRIVE;
            EXIT:    state_nxt = DONE_ST;
            DONE_ST: if (START) state_nxt = ENTER;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; everything is registered below so each
    // output reflects the state it belongs to with no combinational path out.
    always_comb begin
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        err_nxt     = ERR_MASK;
        fidx_nxt    = FAIL_IDX;
        pass_nxt    = PASS;
        aborted_nxt = ABORTED;
        mism        = sns_sync ^ DRV;

        case (state)
            IDLE, DONE_ST: begin
                if (START) begin
                    cnt_nxt     = SETTLE_LOAD;
                    idx_nxt     = 3'd0;
                    err_nxt     = 4'b0000;
                    fidx_nxt    = 3'd0;
                    pass_nxt    = 1'b0;
                    aborted_nxt = 1'b0;
                end
            end
            ENTER: begin
                if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
            end
            DRIVE: begin
                cnt_nxt = SETTLE_LAST;
            end
            SETTLE: begin
                if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
            end
            SAMPLE: begin
                // ERR_MASK only ever gains bits from mismatches, so an empty
                // mask means no earlier pattern in this run has failed.
                err_nxt = ERR_MASK | mism;
                if (mism != 4'b0000 && ERR_MASK == 4'b0000) fidx_nxt = idx;
                if (!ABORT && idx != 3'd7) idx_nxt = idx + 3'd1;
            end
            EXIT: begin
                pass_nxt = (ERR_MASK == 4'b0000) && !ABORTED;
            end
            default: ;
        endcase

        if (ABORT && (state == ENTER || state == DRIVE ||
                      state == SETTLE || state == SAMPLE)) begin
            aborted_nxt = 1'b1;
        end

        in_run_nxt    = (state_nxt == ENTER)  || (state_nxt == DRIVE) ||
                        (state_nxt == SETTLE) || (state_nxt == SAMPLE) ||
                        (state_nxt == EXIT);
        test_mode_nxt = !in_run_nxt;
        busy_nxt      = in_run_nxt;
        done_nxt      = (state == EXIT);
        if (state_nxt == DRIVE || state_nxt == SETTLE || state_nxt == SAMPLE) begin
            drv_nxt = pattern_at(idx_nxt);
        end else begin
            drv_nxt = 4'b0000;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            TEST_MODE <= 1'b1;
            DRV       <= 4'b0000;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ABORTED   <= 1'b0;
            ERR_MASK  <= 4'b0000;
            FAIL_IDX  <= 3'd0;
            idx       <= 3'd0;
            cnt       <= 8'd0;
        end else begin
            TEST_MODE <= test_mode_nxt;
            DRV       <= drv_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
            PASS      <= pass_nxt;
            ABORTED   <= aborted_nxt;
            ERR_MASK  <= err_nxt;
            FAIL_IDX  <= fidx_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule
